// File: rtl/minmax_sched_pkg.sv
// Shared configuration, slot payload and saturating effective-priority helper
// for the minmax_sched issue scheduler.
package minmax_sched_pkg;

  localparam int unsigned IN   = 8;
  localparam int unsigned DATA = 8;
  localparam int unsigned TAG  = 4;
  localparam int unsigned AGE  = 3;

  localparam int unsigned IDX = $clog2(IN);
  localparam int unsigned KEY = 1 + DATA + IDX;
  localparam int unsigned CNT = IDX + 1;

  typedef struct packed {
    logic            valid;
    logic [DATA-1:0] prio;
    logic [TAG-1:0]  tag;
    logic [AGE-1:0]  age;
  } entry_t;

  // prio + age, clamped to the all-ones priority instead of wrapping
  function automatic logic [DATA-1:0] sat_add(input logic [DATA-1:0] prio,
                                              input logic [AGE-1:0]  age);
    logic [DATA:0] sum;
    sum = {1'b0, prio} + {{(DATA + 1 - AGE){1'b0}}, age};
    return sum[DATA] ? {DATA{1'b1}} : sum[DATA-1:0];
  endfunction

endpackage

// File: rtl/sel_minmax.sv
// Combinational min/max selector over IN keys; strict compare keeps the
// lowest index on equal keys. Output reads 0 when en is not at its active level.
module sel_minmax #(
  parameter int unsigned IN      = 8,
  parameter int unsigned DATA    = 8,
  parameter bit          MINMAX_ = 1'b1,
  parameter bit          ACT     = 1'b1
) (
  input  logic                  en,
  input  logic [DATA-1:0]       din [IN],
  output logic [DATA-1:0]       sel_val,
  output logic [$clog2(IN)-1:0] sel_idx
);

  localparam int unsigned IW = $clog2(IN);

  logic [DATA-1:0] best;
  logic [IW-1:0]   best_idx;

  always_comb begin
    best     = din[0];
    best_idx = '0;
    for (int i = 1; i < IN; i++) begin
      if (MINMAX_ ? (din[i] > best) : (din[i] < best)) begin
        best     = din[i];
        best_idx = IW'(i);
      end
    end
    sel_val = '0;
    sel_idx = '0;
    if (en == ACT) begin
      sel_val = best;
      sel_idx = best_idx;
    end
  end

endmodule

// File: rtl/minmax_sched.sv
// IN-entry priority issue scheduler: allocates into the lowest free slot and
// issues the highest aged priority; periodic aging prevents starvation.
module minmax_sched
  import minmax_sched_pkg::*;
#(
  parameter int unsigned AGE_PERIOD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  input  logic [DATA-1:0] alloc_prio,
  input  logic [TAG-1:0]  alloc_tag,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [IDX-1:0]  issue_idx,
  output logic [DATA-1:0] issue_prio,
  output logic [TAG-1:0]  issue_tag,
  output logic [CNT-1:0]  count,
  output logic            empty
);

  localparam int unsigned PW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

  entry_t          slots [IN];
  logic [PW-1:0]   per_cnt;
  logic [KEY-1:0]  keys [IN];
  logic [KEY-1:0]  sel_key;
  logic [IDX-1:0]  sel_idx;
  logic [IDX-1:0]  key_idx;
  logic [IDX-1:0]  free_idx;
  logic            tick;
  logic            alloc_fire;
  logic            issue_fire;

  // Key = {valid, eff, ~idx}: invalid slots lose, equal eff favours low index
  always_comb begin
    for (int i = 0; i < IN; i++) begin
      keys[i] = {slots[i].valid, sat_add(slots[i].prio, slots[i].age), ~IDX'(i)};
    end
  end

  sel_minmax #(
    .IN      (IN),
    .DATA    (KEY),
    .MINMAX_ (1'b1),
    .ACT     (1'b1)
  ) u_sel (
    .en      (1'b1),
    .din     (keys),
    .sel_val (sel_key),
    .sel_idx (sel_idx)
  );

  // The key's inverted index field names the same slot as sel_idx
  assign key_idx     = ~sel_key[IDX-1:0];
  assign issue_valid = sel_key[KEY-1];
  assign issue_idx   = issue_valid ? sel_idx : '0;
  assign issue_prio  = issue_valid ? sel_key[KEY-2:IDX] : '0;
  assign issue_tag   = issue_valid ? slots[key_idx].tag : '0;

  assign alloc_ready = (count < CNT'(IN));
  assign empty       = (count == '0);
  assign tick        = (per_cnt == PW'(AGE_PERIOD - 1));
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign issue_fire  = issue_valid && issue_ready;

  // Lowest-index free slot; a slot being issued this cycle still reads valid
  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < IN; i++) begin
      if (!found && !slots[i].valid) begin
        free_idx = IDX'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IN; i++) slots[i] <= '0;
      count   <= '0;
      per_cnt <= '0;
    end else begin
      per_cnt <= tick ? '0 : per_cnt + PW'(1);
      count   <= flush ? '0 : count + CNT'(alloc_fire) - CNT'(issue_fire);
      for (int i = 0; i < IN; i++) begin
        if (flush) begin
          slots[i].valid <= 1'b0;
        end else if (issue_fire && (IDX'(i) == sel_idx)) begin
          slots[i].valid <= 1'b0;
        end else if (alloc_fire && (IDX'(i) == free_idx)) begin
          slots[i] <= '{valid: 1'b1, prio: alloc_prio, tag: alloc_tag, age: '0};
        end else if (tick && slots[i].valid && (slots[i].age != '1)) begin
          slots[i].age <= slots[i].age + AGE'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_minmax_sched.sv
// Scoreboard bench for minmax_sched: a slot-array reference model predicts the
// visible outputs each cycle; a monitor compares them against the DUT.
module tb_minmax_sched;

  localparam int AP    = 4;
  localparam int NS    = 8;
  localparam int PMAX  = 255;
  localparam int AMAX  = 7;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [7:0] alloc_prio;
  logic [3:0] alloc_tag;
  logic       issue_valid;
  logic       issue_ready;
  logic [2:0] issue_idx;
  logic [7:0] issue_prio;
  logic [3:0] issue_tag;
  logic [3:0] count;
  logic       empty;

  minmax_sched #(.AGE_PERIOD(AP)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_prio  (alloc_prio),
    .alloc_tag   (alloc_tag),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_idx   (issue_idx),
    .issue_prio  (issue_prio),
    .issue_tag   (issue_tag),
    .count       (count),
    .empty       (empty)
  );

  typedef struct {
    bit v;
    int idx;
    int prio;
    int tag;
    int cnt;
    bit ar;
    bit em;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  bit m_valid [NS];
  int m_prio  [NS];
  int m_tag   [NS];
  int m_age   [NS];
  int m_cnt;
  int m_per;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model_out();
    exp_t e;
    int   best_eff;
    e = '{v: 1'b0, idx: 0, prio: 0, tag: 0, cnt: m_cnt, ar: (m_cnt < NS), em: (m_cnt == 0)};
    best_eff = -1;
    for (int j = 0; j < NS; j++) begin
      int eff;
      eff = m_prio[j] + m_age[j];
      if (eff > PMAX) eff = PMAX;
      if (m_valid[j] && eff > best_eff) begin
        best_eff = eff;
        e.v      = 1'b1;
        e.idx    = j;
        e.prio   = eff;
        e.tag    = m_tag[j];
      end
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < NS; j++) begin
      m_valid[j] = 1'b0;
      m_prio[j]  = 0;
      m_tag[j]   = 0;
      m_age[j]   = 0;
    end
    m_cnt = 0;
    m_per = 0;
  endtask

  task automatic model_update(input bit av, input int p, input int t, input bit ir,
                              input bit fl, input exp_t e);
    bit fi, fa, tick;
    int free;
    fi   = e.v && ir;
    fa   = av && (m_cnt < NS) && !fl;
    free = -1;
    for (int j = NS - 1; j >= 0; j--) if (!m_valid[j]) free = j;
    tick  = (m_per == AP - 1);
    m_per = (m_per + 1) % AP;
    if (tick)
      for (int j = 0; j < NS; j++)
        if (m_valid[j] && !(fi && j == e.idx) && m_age[j] < AMAX) m_age[j]++;
    if (fl) begin
      for (int j = 0; j < NS; j++) m_valid[j] = 1'b0;
      m_cnt = 0;
    end else begin
      if (fi) m_valid[e.idx] = 1'b0;
      if (fa) begin
        m_valid[free] = 1'b1;
        m_prio[free]  = p;
        m_tag[free]   = t;
        m_age[free]   = 0;
      end
      m_cnt = m_cnt + int'(fa) - int'(fi);
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, advance model at posedge
  task automatic step(input bit av, input int p, input int t, input bit ir, input bit fl);
    exp_t e;
    @(negedge clk);
    alloc_valid = av;
    alloc_prio  = 8'(p);
    alloc_tag   = 4'(t);
    issue_ready = ir;
    flush       = fl;
    e = model_out();
    exp_q.push_back(e);
    @(posedge clk);
    model_update(av, p, t, ir, fl, e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges: outputs must already be at reset values
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    alloc_valid = 1'b0;
    issue_ready = 1'b0;
    flush       = 1'b0;
    model_clear();
    exp_q.push_back(model_out());
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare the DUT against each predicted output set
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (issue_valid !== e.v || int'(issue_idx) != e.idx || int'(issue_prio) != e.prio ||
            int'(issue_tag) != e.tag || int'(count) != e.cnt || alloc_ready !== e.ar ||
            empty !== e.em) begin
          n_err++;
          $display("FAIL outputs @%0t: got v=%0b idx=%0d prio=%0d tag=%0d cnt=%0d ar=%0b em=%0b, expected v=%0b idx=%0d prio=%0d tag=%0d cnt=%0d ar=%0b em=%0b",
                   $time, issue_valid, issue_idx, issue_prio, issue_tag, count, alloc_ready, empty,
                   e.v, e.idx, e.prio, e.tag, e.cnt, e.ar, e.em);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_prio  = '0;
    alloc_tag   = '0;
    issue_ready = 1'b0;
    model_clear();
    do_reset();
    idle(2);

    // Fill to full with no consumer
    for (int i = 0; i < NS; i++) step(1'b1, 10 + i, i, 1'b0, 1'b0);
    #1;
    chk("full_count", int'(count), 8);
    chk("full_alloc_ready", int'(alloc_ready), 0);

    // Alloc and issue together at full, then at count 7
    step(1'b1, 99, 9, 1'b1, 1'b0);
    #1 chk("full_alloc_dropped", int'(count), 7);
    step(1'b1, 50, 10, 1'b1, 1'b0);
    #1 chk("alloc_issue_count", int'(count), 7);
    idle(2);

    // Flush drops a same-cycle alloc
    step(1'b1, 1, 1, 1'b0, 1'b1);
    #1;
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    idle(2);

    // Drain order with a priority tie
    step(1'b1, 5, 1, 1'b0, 1'b0);
    step(1'b1, 9, 2, 1'b0, 1'b0);
    step(1'b1, 9, 3, 1'b0, 1'b0);
    step(1'b1, 2, 4, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 0, 0, 1'b1, 1'b0);
    #1 chk("drain_empty", int'(empty), 1);

    // Effective priority saturates at 255 rather than wrapping
    step(1'b1, 250, 6, 1'b0, 1'b0);
    idle(40);
    #1 chk("prio_saturate", int'(issue_prio), 255);
    step(1'b0, 0, 0, 1'b1, 1'b0);

    // Age saturates at 7
    step(1'b1, 0, 7, 1'b0, 1'b0);
    idle(40);
    #1 chk("age_saturate", int'(issue_prio), 7);
    step(1'b0, 0, 0, 1'b1, 1'b0);

    // Aging lets an old prio-3 entry overtake a refreshed prio-5 entry
    step(1'b1, 3, 1, 1'b0, 1'b0);
    step(1'b1, 5, 2, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++)
      step((k % 4 == 0) && (k > 0), 5, 2, (k % 4 == 3), 1'b0);
    idle(1);

    // Mid-stream asynchronous reset
    for (int k = 0; k < 6; k++) step(1'b1, 20 + k, k, 1'b0, 1'b0);
    do_reset();
    idle(3);

    // Randomised traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        bit av, ir, fl;
        int p;
        av = ($urandom_range(99) < 60);
        ir = ($urandom_range(99) < 35);
        fl = ($urandom_range(99) < 2);
        p  = ($urandom_range(3) == 0) ? int'($urandom_range(255, 248)) : int'($urandom_range(255));
        step(av, p, int'($urandom_range(15)), ir, fl);
      end
    end
    idle(2);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/minmax_sched.md
Name: minmax_sched

Overview:
- IN-entry priority issue scheduler built around one sel_minmax instance in max mode.
- Requesters allocate entries (priority + tag) through a valid/ready port; the scheduler issues the highest effective-priority entry through a second valid/ready port.
- Waiting entries age periodically so low-priority entries cannot starve.
- Sits between request producers and a single shared execution resource.

Parameters:
- IN, 8, number of entry slots (≥2)
- DATA, 8, priority width
- TAG, 4, opaque tag width carried per entry
- AGE, 3, per-entry age counter width
- AGE_PERIOD, 16, cycles between aging ticks (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  invalidate all entries
- alloc_valid  in  1  allocation request
- alloc_ready  out  1  free slot available
- alloc_prio  in  DATA  base priority of new entry
- alloc_tag  in  TAG  tag of new entry
- issue_valid  out  1  at least one valid entry
- issue_ready  in  1  consumer accepts the issued entry
- issue_idx  out  $clog2(IN)  slot index of the selected entry
- issue_prio  out  DATA  effective priority of the selected entry
- issue_tag  out  TAG  tag of the selected entry
- count  out  $clog2(IN)+1  number of valid entries
- empty  out  1  count==0

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: all valid, age and period-counter state cleared to 0. Resulting outputs: alloc_ready=1, issue_valid=0, count=0, empty=1, issue_idx/prio/tag=0.
- Per-slot state: valid, prio[DATA], tag[TAG], age[AGE].
- Effective priority: eff = prio + age, saturating at 2^DATA-1.
- Selection key per slot: {valid, eff, ~idx}, width 1+DATA+$clog2(IN).
  - The key is fed to sel_minmax with MINMAX_=High and ACT=High.
  - Invalid slots always lose.
  - Ties on eff resolve to the lowest index.
- Issue path: issue_* are combinational from current state; 0-cycle latency from entry valid to issue_valid.
  - issue_valid = any valid.
  - issue_idx comes from the sel_minmax index output.
  - issue_prio = eff of the selected slot. issue_tag = tag of the selected slot.
  - When issue_valid=0, issue_idx/prio/tag read 0.
  - Issue handshake: on issue_valid && issue_ready, the selected slot's valid clears at the next edge.
- Allocation path:
  - alloc_ready = (count < IN), computed from registered state only.
  - On alloc_valid && alloc_ready, the lowest-index invalid slot is written with prio, tag and age=0.
- Simultaneous alloc and issue:
  - Both take effect in the same cycle; count is unchanged.
  - A slot freed by issue is not reused by that cycle's allocation.
  - When full, alloc_ready=0 even if an issue happens in the same cycle.
- Aging:
  - A period counter counts 0..AGE_PERIOD-1 and wraps; tick asserts when the counter = AGE_PERIOD-1.
  - On tick, every valid slot not issued and not newly allocated that cycle increments age, saturating at 2^AGE-1.
- flush: all valid bits clear at the next edge.
  - A same-cycle alloc is dropped; a same-cycle issue handshake still completes from the consumer's view.
  - The period counter is not reset by flush.
- count: registered, updated as count + alloc_fire - issue_fire, or 0 on flush. Never exceeds IN and never underflows.
- Assertion: the bench flags issue_ready sampled while issue_valid=0 as a no-op, not an error.
- Reset mid-operation: asynchronous clear of all state; outputs reach their reset values immediately.

Decomposition:
- Shared package minmax_sched_pkg:
  - localparams IDX=$clog2(IN), KEY=1+DATA+IDX, CNT=IDX+1
  - entry_t struct {valid, prio, tag, age}
  - function sat_add(prio, age)
- Sub-module: sel_minmax, instantiated once, IN=IN, DATA=KEY.
- A priority encoder for free-slot search stays inline.

Test Plan:
- Fill and full: allocate 8 entries with prio 10..17, issue_ready=0 → count=8, alloc_ready=0, issue_idx=7, issue_prio=17.
- Drain order: allocate prio {5,9,9,2} into slots 0..3, hold issue_ready=1 → issue order idx 1,2,0,3 (tie goes to lower index), then empty=1.
- Aging anti-starvation: AGE_PERIOD=4; allocate prio 3 at slot 0; keep one prio-5 entry present (re-allocated after each issue) while issuing every 4 cycles → slot 0's age reaches 3, eff=6 beats 5, slot 0 issues. Also check age saturates at 7.
- Saturation: prio 254 with age 3 → issue_prio=255, no wrap.
- Simultaneous events at full: count=8 with alloc_valid=1 and issue fire → alloc dropped, count=7 next cycle. At count=7 with both firing → count stays 7, and the freed slot is not written.
- Flush and reset: flush with alloc_valid=1 → count=0 next cycle, no entry written. Asynchronous reset asserted mid-stream → issue_valid=0 immediately, and the period counter restarts from 0.
